smem_core_port: RTL

//  Core-side request stage in front of the 16 shared-memory bank arbiters.

---
 rtl/smem_core_port.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/smem_core_port.sv
// -----------------------------------------------------------------------------
// smem_core_port
//
// Core-side request stage in front of the shared-memory bank arbiters. Each
// core owns an independent IDLE/BUSY/DONE FSM: a request is latched in IDLE,
// held stable on the broadcast arbiter buses while BUSY, and completed when
// the owning bank (latched addr[11:8]) pulses this core's finish bit. DONE
// lasts one cycle and drives the core_done pulse.
//
// Optional feature (macro SMEM_TIMEOUT_EN): per-core 8-bit watchdog. A BUSY
// access that sees no finish within TIMEOUT cycles is abandoned with a
// one-cycle core_err pulse. Without the macro core_err is tied low.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high
//   core_req    in   per-core request, sampled only while core_ready is high
//   core_we     in   per-core write enable (1 = write), sampled with core_req
//   core_addr   in   per-core address, core c at [12c+11:12c]
//   core_wdata  in   per-core write data, core c at [8c+7:8c]
//   core_ready  out  per-core FSM is IDLE (combinational from state)
//   core_done   out  per-core one-cycle completion pulse
//   core_rdata  out  per-core read data, held until the next read completes
//   core_err    out  per-core one-cycle timeout pulse
//   arb_read    out  per-core read strobe, broadcast to all banks
//   arb_write   out  per-core write strobe, broadcast to all banks
//   arb_addr    out  latched addresses, same packing as core_addr
//   arb_data    out  latched write data, same packing as core_wdata
//   arb_finish  in   bank b finish vector at [16b+15:16b]
//   arb_rdata   in   bank b data bus at [128b+127:128b], core slice 8c
// -----------------------------------------------------------------------------
module smem_core_port #(
  parameter int N_CORES = 16,
  parameter int N_BANKS = 16,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_CORES-1:0]                  core_req,
  input  logic [N_CORES-1:0]                  core_we,
  input  logic [N_CORES*ADDR_W-1:0]           core_addr,
  input  logic [N_CORES*DATA_W-1:0]           core_wdata,
  output logic [N_CORES-1:0]                  core_ready,
  output logic [N_CORES-1:0]                  core_done,
  output logic [N_CORES*DATA_W-1:0]           core_rdata,
  output logic [N_CORES-1:0]                  core_err,
  output logic [N_CORES-1:0]                  arb_read,
  output logic [N_CORES-1:0]                  arb_write,
  output logic [N_CORES*ADDR_W-1:0]           arb_addr,
  output logic [N_CORES*DATA_W-1:0]           arb_data,
  input  logic [N_BANKS*N_CORES-1:0]          arb_finish,
  input  logic [N_BANKS*N_CORES*DATA_W-1:0]   arb_rdata
);

  localparam int BANK_W = $clog2(N_BANKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                      state_q [N_CORES];
  state_e                      state_d [N_CORES];
  logic [N_CORES-1:0]          read_q,  read_d;
  logic [N_CORES-1:0]          write_q, write_d;
  logic [N_CORES-1:0]          done_q,  done_d;
  logic [N_CORES*ADDR_W-1:0]   addr_q,  addr_d;
  logic [N_CORES*DATA_W-1:0]   data_q,  data_d;
  logic [N_CORES*DATA_W-1:0]   rdata_q, rdata_d;
  logic [BANK_W-1:0]           bank;

`ifdef SMEM_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 255;
  logic [7:0]                  cnt_q [N_CORES];
  logic [7:0]                  cnt_d [N_CORES];
  logic [N_CORES-1:0]          err_q, err_d;
`endif

  // Next-state logic for all cores; each loop iteration is one core's FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    done_d  = '0;
    bank    = '0;
`ifdef SMEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = '0;
`endif
    for (int c = 0; c < N_CORES; c++) begin
      // Owning bank comes from the latched address, not the live core bus.
      bank = addr_q[c*ADDR_W + ADDR_W-1 -: BANK_W];
      case (state_q[c])
        IDLE: begin
          if (core_req[c]) begin
            read_d[c]  = !core_we[c];
            write_d[c] = core_we[c];
            addr_d[c*ADDR_W +: ADDR_W] = core_addr[c*ADDR_W +: ADDR_W];
            data_d[c*DATA_W +: DATA_W] = core_wdata[c*DATA_W +: DATA_W];
`ifdef SMEM_TIMEOUT_EN
            cnt_d[c] = '0;
`endif
            state_d[c] = BUSY;
          end
        end
        BUSY: begin
          // Only the latched bank's finish bit for this core counts; the
          // arbiter data slice is undefined unless that bit is set.
          if (arb_finish[int'(bank)*N_CORES + c]) begin
            if (read_q[c]) begin
              rdata_d[c*DATA_W +: DATA_W] =
                arb_rdata[(int'(bank)*N_CORES + c)*DATA_W +: DATA_W];
            end
            read_d[c]  = 1'b0;
            write_d[c] = 1'b0;
            done_d[c]  = 1'b1;
            state_d[c] = DONE;
          end
`ifdef SMEM_TIMEOUT_EN
          // Counter reads 0 in the first BUSY cycle, so this fires on the
          // TIMEOUT-th BUSY cycle without a finish.
          else if (cnt_q[c] == 8'(TIMEOUT - 1)) begin
            read_d[c]  = 1'b0;
            write_d[c] = 1'b0;
            err_d[c]   = 1'b1;
            state_d[c] = IDLE;
          end else begin
            cnt_d[c] = cnt_q[c] + 8'd1;
          end
`endif
        end
        DONE:    state_d[c] = IDLE;
        default: state_d[c] = IDLE;
      endcase
    end
  end

  // State and registered outputs. Data registers are reset as well because
  // core_rdata/arb_addr/arb_data must read zero out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < N_CORES; c++) begin
        state_q[c] <= IDLE;
`ifdef SMEM_TIMEOUT_EN
        cnt_q[c]   <= '0;
`endif
      end
      read_q  <= '0;
      write_q <= '0;
      done_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
`ifdef SMEM_TIMEOUT_EN
      err_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // the same pre-edge values, regardless of statement order.
      state_q <= state_d;
      read_q  <= read_d;
      write_q <= write_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
`ifdef SMEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    core_ready = '0;
    for (int c = 0; c < N_CORES; c++) begin
      core_ready[c] = (state_q[c] == IDLE);
    end
  end

  assign core_done  = done_q;
  assign core_rdata = rdata_q;
  assign arb_read   = read_q;
  assign arb_write  = write_q;
  assign arb_addr   = addr_q;
  assign arb_data   = data_q;

`ifdef SMEM_TIMEOUT_EN
  assign core_err = err_q;
`else
  assign core_err = '0;
`endif

endmodule
